// File: rtl/params_noc.sv
// NoC-wide parameters, flit format and framing helpers.
package params_noc;

    localparam int VC_NUM = 2;
    localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        HEAD,
        BODY,
        TAIL,
        HEADTAIL
    } flit_label;

    typedef enum logic {
        FR_IDLE,
        FR_PKT
    } frame_state_t;

    typedef struct packed {
        flit_label         label;
        logic [DATA_W-1:0] payload;
    } flit_Data_noVC;

    typedef struct packed {
        flit_Data_noVC   flit;
        logic [VC_W-1:0] vc_Id;
    } flit_Data;

    function automatic logic label_ok(frame_state_t s, flit_label l);
        logic ok;
        ok = 1'b0;
        unique case (s)
            FR_IDLE: ok = (l == HEAD) || (l == HEADTAIL);
            FR_PKT:  ok = (l == BODY) || (l == TAIL);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic frame_state_t frame_next(frame_state_t s, flit_label l);
        frame_state_t n;
        n = s;
        if (s == FR_IDLE && l == HEAD) n = FR_PKT;
        if (s == FR_PKT && l == TAIL) n = FR_IDLE;
        return n;
    endfunction

endpackage

// File: rtl/vc_fifo_slice.sv
// One virtual channel: circular FIFO, occupancy, on/off hysteresis
// and packet framing check.
module vc_fifo_slice
    import params_noc::*;
#(
    parameter int BUFFER_SIZE = 8,
    parameter int OFF_LEVEL   = BUFFER_SIZE - 2,
    parameter int ON_LEVEL    = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wr_en_i,
    input  flit_Data wr_flit_i,
    input  logic     rd_en_i,
    output flit_Data head_o,
    output logic     empty_o,
    output logic     full_o,
    output logic     on_off_o,
    output logic     err_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);

    flit_Data mem_q [BUFFER_SIZE];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    frame_state_t     state_q, state_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             on_off_q, on_off_d;
    logic             err_q, err_d;
    logic             frame_ok;
    logic             do_rd;
    logic             do_wr;

    always_comb begin
        frame_ok = label_ok(state_q, wr_flit_i.flit.label);
        // a read on an empty VC never frees space for a same-cycle write
        do_rd    = rd_en_i && (cnt_q != '0);
        do_wr    = wr_en_i && frame_ok && ((cnt_q != FULL_CNT) || do_rd);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
        cnt_d    = cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        state_d  = do_wr ? frame_next(state_q, wr_flit_i.flit.label) : state_q;
        err_d    = err_q | (wr_en_i & ~do_wr);
        empty_d  = (cnt_d == '0);
        full_d   = (cnt_d == FULL_CNT);
        on_off_d = on_off_q;
        if (int'(cnt_d) >= OFF_LEVEL) begin
            on_off_d = 1'b0;
        end else if (int'(cnt_d) <= ON_LEVEL) begin
            on_off_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= FR_IDLE;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            on_off_q <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            on_off_q <= on_off_d;
            err_q    <= err_d;
        end
    end

    // storage needs no reset: the pointers and empty flag gate it
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_flit_i;
        end
    end

    assign head_o   = empty_q ? '0 : mem_q[rd_ptr_q];
    assign empty_o  = empty_q;
    assign full_o   = full_q;
    assign on_off_o = on_off_q;
    assign err_o    = err_q;

endmodule

// File: rtl/vc_input_buffer.sv
// Per-port NoC input buffer: write demux and read mux around
// one FIFO slice per virtual channel.
module vc_input_buffer
    import params_noc::*;
#(
    parameter int VC_NUM      = params_noc::VC_NUM,
    parameter int BUFFER_SIZE = 8,
    parameter int OFF_LEVEL   = BUFFER_SIZE - 2,
    parameter int ON_LEVEL    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_i,
    input  flit_Data          input_Data,
    input  logic              read_i,
    input  logic [VC_W-1:0]   read_Vc_i,
    output flit_Data          output_Data,
    output logic [VC_NUM-1:0] vc_Empty,
    output logic [VC_NUM-1:0] vc_Full,
    output logic [VC_NUM-1:0] vc_On_Off,
    output logic [VC_NUM-1:0] proto_Err
);

    logic [VC_NUM-1:0] wr_en;
    logic [VC_NUM-1:0] rd_en;
    flit_Data          head [VC_NUM];

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        assign wr_en[v] = write_i && (input_Data.vc_Id == VC_W'(v));
        assign rd_en[v] = read_i && (read_Vc_i == VC_W'(v));

        vc_fifo_slice #(
            .BUFFER_SIZE(BUFFER_SIZE),
            .OFF_LEVEL  (OFF_LEVEL),
            .ON_LEVEL   (ON_LEVEL)
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en_i  (wr_en[v]),
            .wr_flit_i(input_Data),
            .rd_en_i  (rd_en[v]),
            .head_o   (head[v]),
            .empty_o  (vc_Empty[v]),
            .full_o   (vc_Full[v]),
            .on_off_o (vc_On_Off[v]),
            .err_o    (proto_Err[v])
        );
    end

    // out-of-range VC selects read as zero
    always_comb begin
        output_Data = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (read_Vc_i == VC_W'(v)) begin
                output_Data = head[v];
            end
        end
    end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed self-checking bench for vc_input_buffer.
module tb_vc_input_buffer;
    import params_noc::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            write_i = 1'b0;
    flit_Data        input_Data = '0;
    logic            read_i = 1'b0;
    logic [VC_W-1:0] read_Vc_i = '0;
    flit_Data        output_Data;
    logic [1:0]      vc_Empty;
    logic [1:0]      vc_Full;
    logic [1:0]      vc_On_Off;
    logic [1:0]      proto_Err;

    int n_checks = 0;
    int n_errors = 0;

    vc_input_buffer #(
        .VC_NUM     (2),
        .BUFFER_SIZE(8),
        .OFF_LEVEL  (6),
        .ON_LEVEL   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .write_i    (write_i),
        .input_Data (input_Data),
        .read_i     (read_i),
        .read_Vc_i  (read_Vc_i),
        .output_Data(output_Data),
        .vc_Empty   (vc_Empty),
        .vc_Full    (vc_Full),
        .vc_On_Off  (vc_On_Off),
        .proto_Err  (proto_Err)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic flit_Data mk(int vc, flit_label l, int d);
        flit_Data f;
        f.flit.label   = l;
        f.flit.payload = d[DATA_W-1:0];
        f.vc_Id        = vc[VC_W-1:0];
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        write_i = 1'b0;
        read_i  = 1'b0;
    endtask

    task automatic wr(int vc, flit_label l, int d);
        input_Data = mk(vc, l, d);
        write_i    = 1'b1;
        step();
    endtask

    task automatic rd(int vc);
        read_Vc_i = vc[VC_W-1:0];
        read_i    = 1'b1;
        step();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    flit_label lbl3 [3] = '{HEAD, BODY, TAIL};

    initial begin
        apply_reset();
        check("rst_empty", 32'(vc_Empty), 32'h3);
        check("rst_full", 32'(vc_Full), 32'h0);
        check("rst_onoff", 32'(vc_On_Off), 32'h3);
        check("rst_err", 32'(proto_Err), 32'h0);
        check("rst_out", 32'(output_Data), 32'h0);

        // single packet on VC0
        read_Vc_i = 0;
        wr(0, HEAD, 'h11);
        check("pkt_vis", 32'(output_Data), 32'(mk(0, HEAD, 'h11)));
        check("pkt_empty", 32'(vc_Empty), 32'h2);
        wr(0, BODY, 'h12);
        wr(0, TAIL, 'h13);
        for (int i = 0; i < 3; i++) begin
            check("pkt_order", 32'(output_Data),
                  32'(mk(0, lbl3[i], 'h11 + i)));
            rd(0);
        end
        check("pkt_drain", 32'(vc_Empty), 32'h3);
        check("pkt_err", 32'(proto_Err), 32'h0);
        check("pkt_out0", 32'(output_Data), 32'h0);

        // interleaved VCs, VC1 read first
        wr(0, HEAD, 'h21);
        wr(1, HEAD, 'h31);
        wr(0, TAIL, 'h22);
        wr(1, TAIL, 'h32);
        read_Vc_i = 1;
        #1;
        check("il_v1a", 32'(output_Data), 32'(mk(1, HEAD, 'h31)));
        rd(1);
        check("il_v1b", 32'(output_Data), 32'(mk(1, TAIL, 'h32)));
        rd(1);
        check("il_empty", 32'(vc_Empty), 32'h2);
        read_Vc_i = 0;
        #1;
        check("il_v0a", 32'(output_Data), 32'(mk(0, HEAD, 'h21)));
        rd(0);
        check("il_v0b", 32'(output_Data), 32'(mk(0, TAIL, 'h22)));
        rd(0);
        check("il_drain", 32'(vc_Empty), 32'h3);

        // fill VC0, overflow, drain to the on level
        for (int k = 1; k <= 8; k++) begin
            wr(0, (k == 1) ? HEAD : BODY, 'h40 + k - 1);
            check("fill_onoff", 32'(vc_On_Off[0]), (k >= 6) ? 32'h0 : 32'h1);
            check("fill_full", 32'(vc_Full[0]), (k == 8) ? 32'h1 : 32'h0);
        end
        check("fill_noerr", 32'(proto_Err), 32'h0);
        wr(0, BODY, 'h48);
        check("ovf_err", 32'(proto_Err), 32'h1);
        check("ovf_full", 32'(vc_Full[0]), 32'h1);
        for (int k = 1; k <= 6; k++) begin
            check("drain_data", 32'(output_Data),
                  32'(mk(0, (k == 1) ? HEAD : BODY, 'h40 + k - 1)));
            rd(0);
            check("drain_onoff", 32'(vc_On_Off[0]),
                  (8 - k <= 2) ? 32'h1 : 32'h0);
        end
        check("drain_keep", 32'(output_Data), 32'(mk(0, BODY, 'h46)));

        // full VC0 with same-cycle read and write, across pointer wrap
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            wr(0, (k == 0) ? HEAD : BODY, 'h50 + k);
        end
        for (int i = 0; i < 20; i++) begin
            check("rw_data", 32'(output_Data),
                  32'(mk(0, (i == 0) ? HEAD : BODY, 'h50 + i)));
            input_Data = mk(0, BODY, 'h58 + i);
            write_i    = 1'b1;
            rd(0);
            check("rw_full_err", {30'h0, vc_Full[0], proto_Err[0]}, 32'h2);
        end
        check("rw_after", 32'(output_Data), 32'(mk(0, BODY, 'h64)));

        // BODY on an idle VC1
        wr(1, BODY, 'h70);
        check("frm_err", 32'(proto_Err), 32'h2);
        check("frm_empty", 32'(vc_Empty[1]), 32'h1);

        // asynchronous reset with five flits held
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            wr(0, (k == 0) ? HEAD : BODY, 'h80 + k);
        end
        check("ar_pre", 32'(vc_Empty), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_empty", 32'(vc_Empty), 32'h3);
        check("ar_full", 32'(vc_Full), 32'h0);
        check("ar_onoff", 32'(vc_On_Off), 32'h3);
        check("ar_err", 32'(proto_Err), 32'h0);
        check("ar_out", 32'(output_Data), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
